// File: rtl/vesa_stream_decoder_if.sv
// Sync/pixel bundle between the video capture front end and the stream decoder.
// The master drives raw syncs and pixels; the slave returns the annotated stream.
interface vesa_stream_decoder_if #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 12
);
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [DATA_W-1:0] pixel_in;

    logic [DATA_W-1:0] pixel_out;
    logic              pixel_valid;
    logic              h_start;
    logic              h_end;
    logic              v_start;
    logic              v_end;
    logic [CNT_W-1:0]  x_pos;
    logic [CNT_W-1:0]  y_pos;
    logic              line_err;
    logic              frame_err;
    logic              locked;

    modport master (
        output hsync, vsync, de, pixel_in,
        input  pixel_out, pixel_valid, h_start, h_end, v_start, v_end,
        input  x_pos, y_pos, line_err, frame_err, locked
    );

    modport slave (
        input  hsync, vsync, de, pixel_in,
        output pixel_out, pixel_valid, h_start, h_end, v_start, v_end,
        output x_pos, y_pos, line_err, frame_err, locked
    );
endinterface

// File: rtl/vesa_stream_decoder.sv
// DE-driven sync-to-stream converter: registers pixels one cycle, tags them with
// line/frame markers and coordinates, and verifies the frame format for lock.
module vesa_stream_decoder #(
    parameter int DATA_W    = 24,
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int CNT_W     = 12
) (
    input logic                  clk,
    input logic                  rst,
    vesa_stream_decoder_if.slave vid
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] pixel;
        logic              valid;
        logic              h_start;
        logic              h_end;
        logic              v_start;
        logic              v_end;
        logic [CNT_W-1:0]  x_pos;
        logic [CNT_W-1:0]  y_pos;
        logic              line_err;
        logic              frame_err;
        logic              locked;
    } out_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] H_LEN   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LEN   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_ACTIVE - 1);
    localparam logic             HS_INV  = (HSYNC_POL == 0);
    localparam logic             VS_INV  = (VSYNC_POL == 0);

    logic             hs_n, vs_n;
    logic             hs_n_q, hs_n_d;
    logic             vs_n_q, vs_n_d;
    logic             de_q, de_d;
    logic             vs_edge, de_rise, de_fall;
    logic             unused_hs_edge;

    logic [CNT_W-1:0] xc_q, xc_d;
    logic [CNT_W-1:0] yc_q, yc_d;
    logic [CNT_W-1:0] pix_idx;
    logic [CNT_W-1:0] yc_eff;
    logic             h_end_hit;
    logic             line_bad;

    state_t           state_q, state_d;
    logic             bad_q, bad_d;
    logic             frame_good;
    logic             frame_err_d;

    out_t             out_q, out_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Normalise syncs to active-high before edge detection.
    assign hs_n    = vid.hsync ^ HS_INV;
    assign vs_n    = vid.vsync ^ VS_INV;
    assign hs_n_d  = hs_n;
    assign vs_n_d  = vs_n;
    assign de_d    = vid.de;

    assign vs_edge = vs_n & ~vs_n_q;
    assign de_rise = vid.de & ~de_q;
    assign de_fall = ~vid.de & de_q;
    // Line timing comes from DE; the hsync edge is kept only for observability.
    assign unused_hs_edge = hs_n & ~hs_n_q;

    always_comb begin
        pix_idx   = de_rise ? '0 : xc_q;
        // A vsync edge landing on a pixel makes that pixel's line line 0.
        yc_eff    = vs_edge ? '0 : yc_q;
        h_end_hit = vid.de && (pix_idx == H_LAST);
        line_bad  = de_fall && (xc_q != H_LEN);

        xc_d = xc_q;
        if (de_rise) begin
            xc_d = CNT_W'(1);
        end else if (vid.de) begin
            xc_d = sat_inc(xc_q);
        end

        yc_d = yc_q;
        if (vs_edge) begin
            yc_d = '0;
        end else if (de_fall) begin
            yc_d = sat_inc(yc_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        bad_d       = bad_q;
        frame_err_d = 1'b0;
        frame_good  = (yc_q == V_LEN) && !bad_q && !line_bad;

        case (state_q)
            IDLE: begin
                if (vs_edge) begin
                    state_d = MEASURE;
                    bad_d   = 1'b0;
                end
            end
            MEASURE, LOCKED: begin
                // Excess lines poison the frame now; the error is reported at vsync.
                if (line_bad || (yc_q > V_LEN)) begin
                    bad_d = 1'b1;
                end
                if (vs_edge) begin
                    bad_d = 1'b0;
                    if (frame_good) begin
                        state_d = LOCKED;
                    end else begin
                        state_d     = MEASURE;
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d           = out_q;
        out_d.pixel     = vid.pixel_in;
        out_d.valid     = vid.de;
        out_d.h_start   = de_rise;
        out_d.h_end     = h_end_hit;
        out_d.v_start   = de_rise && (yc_eff == '0) && (state_d != IDLE);
        out_d.v_end     = h_end_hit && (yc_eff == V_LAST) && (state_d != IDLE);
        if (vid.de) begin
            out_d.x_pos = pix_idx;
            out_d.y_pos = yc_eff;
        end
        out_d.line_err  = line_bad && (state_q != IDLE);
        out_d.frame_err = frame_err_d;
        out_d.locked    = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_n_q  <= 1'b0;
            vs_n_q  <= 1'b0;
            de_q    <= 1'b0;
            xc_q    <= '0;
            yc_q    <= '0;
            state_q <= IDLE;
            bad_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            hs_n_q  <= hs_n_d;
            vs_n_q  <= vs_n_d;
            de_q    <= de_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            state_q <= state_d;
            bad_q   <= bad_d;
            out_q   <= out_d;
        end
    end

    assign vid.pixel_out   = out_q.pixel;
    assign vid.pixel_valid = out_q.valid;
    assign vid.h_start     = out_q.h_start;
    assign vid.h_end       = out_q.h_end;
    assign vid.v_start     = out_q.v_start;
    assign vid.v_end       = out_q.v_end;
    assign vid.x_pos       = out_q.x_pos;
    assign vid.y_pos       = out_q.y_pos;
    assign vid.line_err    = out_q.line_err;
    assign vid.frame_err   = out_q.frame_err;
    assign vid.locked      = out_q.locked;
endmodule

// File: tb/tb_vesa_stream_decoder.sv
// Bench for vesa_stream_decoder: frame-level model builds per-cycle expectations,
// checked against an active-high and an active-low sync instance every cycle.
module tb_vesa_stream_decoder;
    localparam int DW   = 8;
    localparam int H    = 8;
    localparam int V    = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct {
        logic [DW-1:0] pix;
        logic          vld, hs, he, vs, ve;
        logic [CW-1:0] x, y;
        logic          le, fe, lk;
        bit            chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vesa_stream_decoder_if #(.DATA_W(DW), .CNT_W(CW)) vp ();
    vesa_stream_decoder_if #(.DATA_W(DW), .CNT_W(CW)) vn ();

    vesa_stream_decoder #(.DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .HSYNC_POL(1),
                          .VSYNC_POL(1), .CNT_W(CW))
        dut_p (.clk(clk), .rst(rst), .vid(vp.slave));
    vesa_stream_decoder #(.DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .HSYNC_POL(0),
                          .VSYNC_POL(0), .CNT_W(CW))
        dut_n (.clk(clk), .rst(rst), .vid(vn.slave));

    int checks = 0;
    int failures = 0;

    // Frame-level model state: 0 idle, 1 measuring, 2 locked.
    int            mode = 0;
    int            lines = 0;
    bit            bad = 1'b0;
    logic [CW-1:0] last_x = '0;
    logic [CW-1:0] last_y = '0;

    exp_t exp_in, exp_out;
    int hs_cnt, he_cnt, vs_cnt, ve_cnt, le_cnt, fe_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic cmp(input string t, input logic [DW-1:0] pix, input logic vld,
                       input logic hs, input logic he, input logic vs, input logic ve,
                       input logic [CW-1:0] x, input logic [CW-1:0] y,
                       input logic le, input logic fe, input logic lk);
        chk({t, ".pixel_out"},   32'(pix), 32'(exp_out.pix));
        chk({t, ".pixel_valid"}, 32'(vld), 32'(exp_out.vld));
        chk({t, ".h_start"},     32'(hs),  32'(exp_out.hs));
        chk({t, ".h_end"},       32'(he),  32'(exp_out.he));
        chk({t, ".v_start"},     32'(vs),  32'(exp_out.vs));
        chk({t, ".v_end"},       32'(ve),  32'(exp_out.ve));
        chk({t, ".x_pos"},       32'(x),   32'(exp_out.x));
        chk({t, ".y_pos"},       32'(y),   32'(exp_out.y));
        chk({t, ".line_err"},    32'(le),  32'(exp_out.le));
        chk({t, ".frame_err"},   32'(fe),  32'(exp_out.fe));
        chk({t, ".locked"},      32'(lk),  32'(exp_out.lk));
    endtask

    always @(posedge clk) exp_out <= exp_in;

    always @(negedge clk) begin
        if (exp_out.chk) begin
            cmp("pos", vp.pixel_out, vp.pixel_valid, vp.h_start, vp.h_end, vp.v_start,
                vp.v_end, vp.x_pos, vp.y_pos, vp.line_err, vp.frame_err, vp.locked);
            cmp("neg", vn.pixel_out, vn.pixel_valid, vn.h_start, vn.h_end, vn.v_start,
                vn.v_end, vn.x_pos, vn.y_pos, vn.line_err, vn.frame_err, vn.locked);
            hs_cnt += int'(vp.h_start);
            he_cnt += int'(vp.h_end);
            vs_cnt += int'(vp.v_start);
            ve_cnt += int'(vp.v_end);
            le_cnt += int'(vp.line_err);
            fe_cnt += int'(vp.frame_err);
        end
    end

    function automatic exp_t base_exp(input logic [DW-1:0] px);
        exp_t e;
        e.pix = px;  e.vld = 1'b0;
        e.hs = 1'b0; e.he = 1'b0; e.vs = 1'b0; e.ve = 1'b0;
        e.x = last_x; e.y = last_y;
        e.le = 1'b0; e.fe = 1'b0;
        e.lk = (mode == 2);
        e.chk = 1'b1;
        return e;
    endfunction

    task automatic drive(input bit hs, input bit vs, input bit d, input logic [DW-1:0] px,
                         input bit r, input exp_t e);
        rst = r;
        vp.hsync = hs;  vp.vsync = vs;  vp.de = d; vp.pixel_in = px;
        vn.hsync = ~hs; vn.vsync = ~vs; vn.de = d; vn.pixel_in = px;
        exp_in = e;
        @(posedge clk);
        #1;
    endtask

    // Closing a frame: good means exactly V lines and no bad line since last vsync.
    task automatic frame_eval(output logic fe);
        bit good;
        good  = (lines == V) && !bad;
        fe    = (mode != 0) && !good;
        mode  = (mode == 0) ? 1 : (good ? 2 : 1);
        lines = 0;
        bad   = 1'b0;
    endtask

    task automatic model_reset();
        mode = 0; lines = 0; bad = 1'b0; last_x = '0; last_y = '0;
    endtask

    task automatic reset_cycle(input bit d);
        exp_t e;
        model_reset();
        e = base_exp('0);
        drive(1'b0, 1'b0, d, DW'($urandom), 1'b1, e);
    endtask

    task automatic blank(input int n, input bit hs_pulse);
        exp_t e;
        logic [DW-1:0] px;
        for (int i = 0; i < n; i++) begin
            px = DW'($urandom);
            e = base_exp(px);
            drive(hs_pulse && (i == 1), 1'b0, 1'b0, px, 1'b0, e);
        end
    endtask

    task automatic vsync(input int n);
        exp_t e;
        logic fe;
        logic [DW-1:0] px;
        for (int i = 0; i < n; i++) begin
            fe = 1'b0;
            if (i == 0) frame_eval(fe);
            px = DW'($urandom);
            e = base_exp(px);
            e.fe = fe;
            drive(1'b0, 1'b1, 1'b0, px, 1'b0, e);
        end
    endtask

    // One DE run of len pixels plus its falling-edge cycle; optional reset at pixel rst_at.
    task automatic run_line(input int len, input bit vs_first, input int rst_at);
        exp_t e;
        logic fe;
        logic [DW-1:0] px;
        int seg, k, sl;
        seg = 0;
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                reset_cycle(1'b1);
                seg = i + 1;
                continue;
            end
            fe = 1'b0;
            if (vs_first && i == 0) frame_eval(fe);
            k  = i - seg;
            px = DW'($urandom);
            e = base_exp(px);
            e.fe  = fe;
            e.vld = 1'b1;
            e.x   = CW'((k > MAXC) ? MAXC : k);
            e.y   = CW'((lines > MAXC) ? MAXC : lines);
            e.hs  = (k == 0);
            e.he  = (k == H - 1);
            e.vs  = (k == 0) && (lines == 0) && (mode != 0);
            e.ve  = e.he && (lines == V - 1) && (mode != 0);
            last_x = e.x;
            last_y = e.y;
            drive(1'b0, vs_first && (i == 0), 1'b1, px, 1'b0, e);
        end
        sl = len - seg;
        if (sl > MAXC) sl = MAXC;
        px = DW'($urandom);
        e = base_exp(px);
        e.le = (sl != H) && (mode != 0);
        if (e.le) bad = 1'b1;
        lines = (lines < MAXC) ? lines + 1 : MAXC;
        drive(1'b0, 1'b0, 1'b0, px, 1'b0, e);
    endtask

    task automatic frame(input int n, input int bad_l, input int bad_len,
                         input int rst_l, input int rst_p, input bit vs_in_line);
        hs_cnt = 0; he_cnt = 0; vs_cnt = 0; ve_cnt = 0; le_cnt = 0; fe_cnt = 0;
        if (!vs_in_line) begin
            vsync(2);
            blank(3, 1'b0);
        end
        for (int l = 0; l < n; l++) begin
            run_line((l == bad_l) ? bad_len : H, vs_in_line && (l == 0),
                     (l == rst_l) ? rst_p : -1);
            blank(3, 1'b1);
        end
    endtask

    initial begin
        exp_in.chk = 1'b0;
        reset_cycle(1'b0);
        reset_cycle(1'b0);
        blank(4, 1'b1);

        frame(4, -1, 0, -1, 0, 1'b0);                       // F1: measuring
        chk("f1_h_start_cnt", hs_cnt, 4);
        chk("f1_h_end_cnt", he_cnt, 4);
        chk("f1_v_start_cnt", vs_cnt, 1);
        chk("f1_v_end_cnt", ve_cnt, 1);
        chk("f1_line_err_cnt", le_cnt, 0);
        chk("f1_locked", vp.locked, 0);
        frame(4, -1, 0, -1, 0, 1'b0);                       // F2: locks at opening vsync
        chk("f2_locked", vp.locked, 1);
        chk("f2_frame_err_cnt", fe_cnt, 0);
        frame(4, -1, 0, -1, 0, 1'b0);                       // F3
        frame(4, 2, 7, -1, 0, 1'b0);                        // F4: short line 2
        chk("f4_line_err_cnt", le_cnt, 1);
        chk("f4_h_end_cnt", he_cnt, 3);
        chk("f4_locked", vp.locked, 1);
        frame(4, -1, 0, -1, 0, 1'b0);                       // F5: drops lock
        chk("f5_frame_err_cnt", fe_cnt, 1);
        chk("f5_locked", vp.locked, 0);
        frame(4, -1, 0, -1, 0, 1'b0);                       // F6: relocks
        chk("f6_locked", vp.locked, 1);
        frame(5, -1, 0, -1, 0, 1'b0);                       // F7: five lines
        chk("f7_v_end_cnt", ve_cnt, 1);
        chk("f7_h_start_cnt", hs_cnt, 5);
        frame(4, -1, 0, -1, 0, 1'b0);                       // F8: error for F7
        chk("f8_frame_err_cnt", fe_cnt, 1);
        chk("f8_locked", vp.locked, 0);
        frame(4, -1, 0, 1, 3, 1'b0);                        // F9: reset mid-line 1
        chk("f9_v_start_cnt", vs_cnt, 1);
        chk("f9_v_end_cnt", ve_cnt, 0);
        chk("f9_h_start_cnt", hs_cnt, 5);
        chk("f9_line_err_cnt", le_cnt, 0);
        chk("f9_locked", vp.locked, 0);
        frame(4, -1, 0, -1, 0, 1'b0);                       // F10: idle -> measure
        chk("f10_locked", vp.locked, 0);
        chk("f10_frame_err_cnt", fe_cnt, 0);
        frame(4, -1, 0, -1, 0, 1'b0);                       // F11: relocks
        chk("f11_locked", vp.locked, 1);
        frame(4, -1, 0, -1, 0, 1'b1);                       // F12: vsync on first pixel
        chk("f12_v_start_cnt", vs_cnt, 1);
        chk("f12_h_start_cnt", hs_cnt, 4);
        chk("f12_locked", vp.locked, 1);
        frame(4, 1, 20, -1, 0, 1'b0);                       // F13: overlong line saturates
        chk("f13_line_err_cnt", le_cnt, 1);
        chk("f13_h_end_cnt", he_cnt, 4);
        frame(4, -1, 0, -1, 0, 1'b0);                       // F14
        chk("f14_frame_err_cnt", fe_cnt, 1);
        chk("f14_locked", vp.locked, 0);
        blank(4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
